// File: rtl/kf8259_in_service_control.sv
// KF8259 priority resolver, in-service register and two-pulse INTA sequencer.
// Selects the highest-priority eligible request under rotation and nests it against the ISR.
module kf8259_in_service_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] interrupt_request_register,
    input  logic [7:0] interrupt_mask,
    input  logic [2:0] priority_rotate,
    input  logic       auto_eoi_config,
    input  logic       interrupt_acknowledge,
    input  logic       end_of_interrupt_nonspecific,
    input  logic       end_of_interrupt_specific,
    input  logic [2:0] eoi_level,
    output logic       interrupt,
    output logic       freeze,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [2:0] interrupt_level,
    output logic       interrupt_level_valid,
    output logic       spurious
);

    typedef enum logic [1:0] {IDLE, ACK1, GAP, ACK2} state_t;

    state_t     r_state, w_next_state;
    logic       r_ack_d;
    logic [7:0] r_isr;
    logic       r_interrupt;
    logic [7:0] r_clear;
    logic [2:0] r_level;
    logic       r_spurious;

    logic [7:0] w_eligible;
    logic       w_elig_found, w_isr_found;
    logic [2:0] w_elig_lvl, w_ceil_lvl;
    logic [2:0] w_elig_rank, w_ceil_rank;
    logic       w_request;
    logic       w_ack_rise, w_ack_fall, w_enter_ack1;
    logic [7:0] w_isr_set, w_isr_clr;

    // Returns {found, level}: first set bit scanning from (lowest+1) mod 8 round to lowest.
    function automatic logic [3:0] highest(input logic [7:0] v, input logic [2:0] lowest);
        logic       found;
        logic [2:0] sel;
        logic [2:0] lvl;
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            lvl = lowest + 3'd1 + 3'(k);
            if (!found && v[lvl]) begin
                found = 1'b1;
                sel   = lvl;
            end
        end
        return {found, sel};
    endfunction

    assign w_eligible                 = interrupt_request_register & ~interrupt_mask;
    assign {w_elig_found, w_elig_lvl} = highest(w_eligible, priority_rotate);
    assign {w_isr_found, w_ceil_lvl}  = highest(r_isr, priority_rotate);

    // Rank 0 is the highest priority; 3-bit wrap makes the rotation implicit.
    assign w_elig_rank = w_elig_lvl - priority_rotate - 3'd1;
    assign w_ceil_rank = w_ceil_lvl - priority_rotate - 3'd1;
    assign w_request   = w_elig_found && (!w_isr_found || (w_elig_rank < w_ceil_rank));

    assign w_ack_rise   = interrupt_acknowledge & ~r_ack_d;
    assign w_ack_fall   = ~interrupt_acknowledge & r_ack_d;
    assign w_enter_ack1 = (r_state == IDLE) && w_ack_rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_ack_rise) w_next_state = ACK1;
            ACK1:    if (w_ack_fall) w_next_state = GAP;
            GAP:     if (w_ack_rise) w_next_state = ACK2;
            ACK2:    if (w_ack_fall) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Set is OR-ed after the clears so an ACK1 set beats an EOI on the same bit.
    always_comb begin
        w_isr_set = '0;
        w_isr_clr = '0;
        if (w_enter_ack1 && w_elig_found)
            w_isr_set[w_elig_lvl] = 1'b1;
        if (end_of_interrupt_nonspecific && w_isr_found)
            w_isr_clr[w_ceil_lvl] = 1'b1;
        if (end_of_interrupt_specific)
            w_isr_clr[eoi_level] = 1'b1;
        if ((r_state == ACK2) && w_ack_fall && auto_eoi_config && !r_spurious)
            w_isr_clr[r_level] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ack_d     <= 1'b0;
            r_isr       <= '0;
            r_interrupt <= 1'b0;
            r_clear     <= '0;
            r_level     <= '0;
            r_spurious  <= 1'b0;
        end else begin
            r_ack_d     <= interrupt_acknowledge;
            r_isr       <= (r_isr & ~w_isr_clr) | w_isr_set;
            r_interrupt <= (r_state == IDLE) && !w_ack_rise && w_request;
            r_clear     <= w_isr_set;
            if (w_enter_ack1) begin
                r_level    <= w_elig_found ? w_elig_lvl : 3'd7;
                r_spurious <= !w_elig_found;
            end else if ((r_state == ACK2) && w_ack_fall) begin
                r_spurious <= 1'b0;
            end
        end
    end

    assign interrupt               = r_interrupt;
    assign freeze                  = (r_state != IDLE);
    assign clear_interrupt_request = r_clear;
    assign in_service_register     = r_isr;
    assign interrupt_level         = r_level;
    assign interrupt_level_valid   = (r_state == ACK2);
    assign spurious                = r_spurious;

endmodule

// File: tb/tb_kf8259_in_service_control.sv
// Bench for kf8259_in_service_control: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the 8259 acknowledge rules.
module tb_kf8259_in_service_control;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] irr, mask;
    logic [2:0] rot;
    logic       auto_eoi, ack, eoi_ns, eoi_sp;
    logic [2:0] eoi_lvl;

    logic       interrupt, freeze, interrupt_level_valid, spurious;
    logic [7:0] clear_interrupt_request, in_service_register;
    logic [2:0] interrupt_level;

    always #5 clock = ~clock;

    kf8259_in_service_control dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .interrupt_request_register   (irr),
        .interrupt_mask               (mask),
        .priority_rotate              (rot),
        .auto_eoi_config              (auto_eoi),
        .interrupt_acknowledge        (ack),
        .end_of_interrupt_nonspecific (eoi_ns),
        .end_of_interrupt_specific    (eoi_sp),
        .eoi_level                    (eoi_lvl),
        .interrupt                    (interrupt),
        .freeze                       (freeze),
        .clear_interrupt_request      (clear_interrupt_request),
        .in_service_register          (in_service_register),
        .interrupt_level              (interrupt_level),
        .interrupt_level_valid        (interrupt_level_valid),
        .spurious                     (spurious)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_edges counts INTA edges seen in the current acknowledge sequence.
    int         m_edges;
    bit         m_ack_prev;
    logic [7:0] m_isr, m_clear;
    int         m_level;
    bit         m_int, m_spur;

    function automatic int top(input logic [7:0] v, input int low);
        for (int k = 1; k <= 8; k++) begin
            int l = (low + k) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int rank(input int l, input int low);
        return (l - low - 1 + 16) % 8;
    endfunction

    task automatic model_reset();
        m_edges = 0; m_ack_prev = 0; m_isr = '0; m_clear = '0;
        m_level = 0; m_int = 0; m_spur = 0;
    endtask

    task automatic model_clock();
        int         e, c;
        bit         req, rise, fall;
        logic [7:0] isr_n;
        e     = top(irr & ~mask, int'(rot));
        c     = top(m_isr, int'(rot));
        req   = (e >= 0) && (c < 0 || rank(e, int'(rot)) < rank(c, int'(rot)));
        rise  = ack && !m_ack_prev;
        fall  = !ack && m_ack_prev;
        isr_n = m_isr;
        if (eoi_ns && c >= 0) isr_n[c] = 1'b0;
        if (eoi_sp) isr_n[eoi_lvl] = 1'b0;
        m_clear = '0;
        case (m_edges)
            0: if (rise) begin
                   m_edges = 1;
                   m_int   = 0;
                   if (e < 0) begin
                       m_spur = 1; m_level = 7;
                   end else begin
                       m_spur = 0; m_level = e;
                       isr_n[e] = 1'b1;
                       m_clear[e] = 1'b1;
                   end
               end else begin
                   m_int = req;
               end
            1: begin m_int = 0; if (fall) m_edges = 2; end
            2: begin m_int = 0; if (rise) m_edges = 3; end
            default: begin
                m_int = 0;
                if (fall) begin
                    if (auto_eoi && !m_spur) isr_n[m_level] = 1'b0;
                    m_spur  = 0;
                    m_edges = 0;
                end
            end
        endcase
        m_isr      = isr_n;
        m_ack_prev = ack;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".int"},   {7'b0, interrupt},             {7'b0, m_int});
        check({tag, ".frz"},   {7'b0, freeze},                {7'b0, m_edges != 0});
        check({tag, ".clr"},   clear_interrupt_request,       m_clear);
        check({tag, ".isr"},   in_service_register,           m_isr);
        check({tag, ".lvl"},   {5'b0, interrupt_level},       8'(m_level));
        check({tag, ".valid"}, {7'b0, interrupt_level_valid}, {7'b0, m_edges == 3});
        check({tag, ".spur"},  {7'b0, spurious},              {7'b0, m_spur});
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_clock();
        #1;
        check_all(tag);
        irr = irr & ~m_clear;
    endtask

    task automatic do_reset();
        ack = 0; eoi_ns = 0; eoi_sp = 0;
        reset_n = 0;
        #2;
        model_reset();
        check_all("rst");
        @(negedge clock);
        reset_n = 1;
    endtask

    task automatic ack_seq(input string tag, input logic [2:0] exp_lvl);
        ack = 1; step(tag);
        check({tag, ".ack1_lvl"}, {5'b0, interrupt_level}, {5'b0, exp_lvl});
        ack = 0; step(tag);
        ack = 1; step(tag);
        check({tag, ".ack2_valid"}, {7'b0, interrupt_level_valid}, 8'd1);
        ack = 0; step(tag);
    endtask

    initial begin
        irr = '0; mask = '0; rot = 3'd7; auto_eoi = 0; eoi_lvl = '0;
        ack = 0; eoi_ns = 0; eoi_sp = 0; reset_n = 1;
        model_reset();
        do_reset();

        // Single request at level 3
        irr = 8'h08; step("single");
        check("single.int_up", {7'b0, interrupt}, 8'd1);
        ack = 1; step("single");
        check("single.isr", in_service_register, 8'h08);
        check("single.clr", clear_interrupt_request, 8'h08);
        check("single.frz", {7'b0, freeze}, 8'd1);
        step("single");
        check("single.clr_gone", clear_interrupt_request, 8'h00);
        ack = 0; step("single");
        ack = 1; step("single");
        check("single.valid", {7'b0, interrupt_level_valid}, 8'd1);
        ack = 0; step("single");
        check("single.idle_frz", {7'b0, freeze}, 8'd0);
        eoi_ns = 1; step("single"); eoi_ns = 0;
        check("single.eoi", in_service_register, 8'h00);

        // Fully nested: ISR level 2 blocks level 2 and 5
        irr = 8'h04; step("nest");
        ack_seq("nest", 3'd2);
        irr = 8'h24; step("nest"); step("nest");
        check("nest.blocked", {7'b0, interrupt}, 8'd0);
        eoi_ns = 1; step("nest"); eoi_ns = 0;
        check("nest.eoi", in_service_register, 8'h00);
        step("nest");
        check("nest.int_up", {7'b0, interrupt}, 8'd1);
        ack_seq("nest", 3'd2);

        // Rotation
        do_reset();
        rot = 3'd2; irr = 8'h81; step("rot");
        ack_seq("rot_l2", 3'd7);
        do_reset();
        rot = 3'd7; irr = 8'h81; step("rot");
        ack_seq("rot_l7", 3'd0);

        // Spurious: request vanishes before INTA
        do_reset();
        irr = 8'h08; step("spur");
        irr = 8'h00; ack = 1; step("spur");
        check("spur.flag", {7'b0, spurious}, 8'd1);
        check("spur.lvl",  {5'b0, interrupt_level}, 8'd7);
        check("spur.isr",  in_service_register, 8'h00);
        check("spur.clr",  clear_interrupt_request, 8'h00);
        ack = 0; step("spur"); ack = 1; step("spur"); ack = 0; step("spur");

        // Auto-EOI
        do_reset();
        auto_eoi = 1; irr = 8'h40; step("aeoi");
        ack_seq("aeoi", 3'd6);
        check("aeoi.isr_cleared", in_service_register, 8'h00);
        auto_eoi = 0;

        // Asynchronous reset while in GAP
        do_reset();
        irr = 8'h10; step("rgap");
        ack = 1; step("rgap"); ack = 0; step("rgap");
        check("rgap.in_gap", {7'b0, freeze}, 8'd1);
        irr = 8'h10;
        reset_n = 0; #1;
        model_reset();
        check_all("rgap_async");
        check("rgap.frz0", {7'b0, freeze}, 8'd0);
        @(negedge clock); reset_n = 1;
        step("rgap");
        check("rgap.int_back", {7'b0, interrupt}, 8'd1);

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) irr = irr | 8'($urandom);
            if ($urandom_range(0, 31) == 0) mask = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 63) == 0) rot = 3'($urandom);
            if ($urandom_range(0, 63) == 0) auto_eoi = 1'($urandom);
            if ($urandom_range(0, 2) == 0) ack = ~ack;
            eoi_ns  = ($urandom_range(0, 7) == 0);
            eoi_sp  = ($urandom_range(0, 7) == 0);
            eoi_lvl = 3'($urandom);
            step("rand");
        end
        eoi_ns = 0; eoi_sp = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
